// File: rtl/rv16_fetch_queue.sv
// In-order instruction fetch queue: issues memory requests, buffers returned words with their PCs,
// and feeds decode; redirects and flushes squash both queued and in-flight fetches.
module rv16_fetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              ILEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     o_imem_req,
  output logic [XLEN-1:0]          o_imem_addr,
  input  logic                     i_imem_gnt,
  input  logic                     i_imem_rvalid,
  input  logic [ILEN-1:0]          i_imem_rdata,
  input  logic                     i_redirect,
  input  logic [XLEN-1:0]          i_redirect_pc,
  input  logic                     i_flush,
  input  logic                     i_stall,
  output logic                     o_fetch_valid,
  output logic [ILEN-1:0]          o_fetch_data,
  output logic [XLEN-1:0]          o_fetch_pc,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 2;
  localparam logic [XLEN-1:0] STEP       = XLEN'(ILEN / 8);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));

  logic [ILEN-1:0] mem_data_r [DEPTH];
  logic [XLEN-1:0] mem_pc_r   [DEPTH];
  logic [AW-1:0]   rd_ptr_r, wr_ptr_r, rd_ptr_s, wr_ptr_s;
  logic [CW-1:0]   count_r, outstanding_r, discard_r;
  logic [CW-1:0]   count_s, outstanding_s, discard_s;
  logic [XLEN-1:0] fpc_r, wr_pc_r, raw_target_s, target_s;
  logic            fetch_valid_r;
  logic [ILEN-1:0] fetch_data_r, head_data_s;
  logic [XLEN-1:0] fetch_pc_r, head_pc_s;
  logic [SW-1:0]   inflight_s, occupancy_s;
  logic            kill_s, req_s, accept_s, drop_s, retire_s, push_s, pop_s;

  // Request gating, response routing and next-state counters
  always_comb begin
    kill_s        = i_redirect || i_flush;
    inflight_s    = SW'(outstanding_r) + SW'(discard_r);
    occupancy_s   = inflight_s + SW'(count_r);
    req_s         = rst_n && !kill_s && (occupancy_s < SW'(DEPTH))
                    && (inflight_s < SW'(MAX_OUTSTANDING));
    accept_s      = req_s && i_imem_gnt;
    // Squashed requests drain first; they are always the oldest in flight.
    drop_s        = i_imem_rvalid && (discard_r != CW'(0));
    retire_s      = i_imem_rvalid && (discard_r == CW'(0)) && (outstanding_r != CW'(0));
    push_s        = retire_s && !kill_s;
    pop_s         = fetch_valid_r && !i_stall && !kill_s;
    outstanding_s = outstanding_r + CW'(accept_s) - CW'(retire_s);
    discard_s     = discard_r - CW'(drop_s);
    count_s       = count_r + CW'(push_s) - CW'(pop_s);
    rd_ptr_s      = rd_ptr_r + AW'(pop_s);
    wr_ptr_s      = wr_ptr_r + AW'(push_s);
    if (push_s && (rd_ptr_s == wr_ptr_r)) begin
      head_data_s = i_imem_rdata;
      head_pc_s   = wr_pc_r;
    end else begin
      head_data_s = mem_data_r[rd_ptr_s];
      head_pc_s   = mem_pc_r[rd_ptr_s];
    end
    if (i_redirect) begin
      raw_target_s = i_redirect_pc;
    end else if (count_r != CW'(0)) begin
      raw_target_s = fetch_pc_r;
    end else begin
      raw_target_s = wr_pc_r;
    end
    target_s = raw_target_s & ALIGN_MASK;
  end

  // Queue storage
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_data_r[wr_ptr_r] <= i_imem_rdata;
      mem_pc_r[wr_ptr_r]   <= wr_pc_r;
    end
  end

  // Control state and registered head
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r      <= AW'(0);
      wr_ptr_r      <= AW'(0);
      count_r       <= CW'(0);
      outstanding_r <= CW'(0);
      discard_r     <= CW'(0);
      fpc_r         <= RESET_PC;
      wr_pc_r       <= RESET_PC;
      fetch_valid_r <= 1'b0;
      fetch_data_r  <= ILEN'(0);
      fetch_pc_r    <= XLEN'(0);
    end else if (kill_s) begin
      rd_ptr_r      <= AW'(0);
      wr_ptr_r      <= AW'(0);
      count_r       <= CW'(0);
      outstanding_r <= CW'(0);
      discard_r     <= discard_s + outstanding_s;
      fpc_r         <= target_s;
      wr_pc_r       <= target_s;
      fetch_valid_r <= 1'b0;
    end else begin
      rd_ptr_r      <= rd_ptr_s;
      wr_ptr_r      <= wr_ptr_s;
      count_r       <= count_s;
      outstanding_r <= outstanding_s;
      discard_r     <= discard_s;
      if (accept_s) fpc_r <= fpc_r + STEP;
      if (push_s) wr_pc_r <= wr_pc_r + STEP;
      fetch_valid_r <= (count_s != CW'(0));
      if (count_s != CW'(0)) begin
        fetch_data_r <= head_data_s;
        fetch_pc_r   <= head_pc_s;
      end
    end
  end

  assign o_imem_req    = req_s;
  assign o_imem_addr   = fpc_r;
  assign o_fetch_valid = fetch_valid_r;
  assign o_fetch_data  = fetch_data_r;
  assign o_fetch_pc    = fetch_pc_r;
  assign o_count       = count_r;
  assign o_full        = (count_r == CW'(DEPTH));
  assign o_empty       = (count_r == CW'(0));

endmodule
